// File: rtl/ins_loader_if.sv
// Host byte link plus the loader's write port into the instruction BRAM.
// The host side (byte source / BRAM observer) uses master; the loader uses slave.
interface ins_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/ins_loader.sv
// Boot loader: parses SYNC/LEN/payload/CKSUM frames into the instruction BRAM and
// holds the core until a frame verifies. Optional idle timeout: LOADER_TIMEOUT_EN.
module ins_loader #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  ins_loader_if.slave   bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [ADDR_W:0] byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              accept;
  logic [ADDR_W:0]   cnt_inc;
  logic [16:0]       len_new;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign accept  = bus.in_valid && (state_q != S_DONE);
  assign cnt_inc = cnt_q + 1'b1;
  assign len_new = {1'b0, bus.in_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d = S_LEN_LO;
          err_d   = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          sum_d   = '0;
          hold_d  = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_new[15:0];
          if (len_new > LEN_MAX) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_new == 17'd0) begin
            state_d = S_CKSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Write is registered here and shows on the BRAM port one cycle later.
        if (accept) begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          din_d  = bus.in_data;
          cnt_d  = cnt_inc;
          sum_d  = sum_q + bus.in_data;
          if (17'(cnt_inc) == {1'b0, len_q})
            state_d = S_CKSUM;
        end
      end
      S_CKSUM: begin
        if (accept) begin
          if (bus.in_data == sum_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q == S_LEN_LO || state_q == S_LEN_HI ||
         state_q == S_DATA   || state_q == S_CKSUM) && !accept) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign cpu_hold      = hold_q;
  assign load_done     = (state_q == S_DONE);
  assign load_err      = err_q;
  assign byte_cnt      = cnt_q;

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
Boot-time program loader that sits directly upstream of the instruction BRAM (bram_8_4096_ins_shell). It consumes a framed byte stream (sync, length, payload, checksum) from a host link and writes the payload bytewise into the 8-bit instruction BRAM. It holds the CPU core (PC_ctrl, Metronome) in hold until a frame has loaded and verified.
- Port A of the instruction BRAM is muxed between this block (while cpu_hold=1) and Ins_buffer (otherwise).

Parameters:
ADDR_W, 12, instruction BRAM byte-address width; capacity 2^ADDR_W bytes
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1000000, idle-cycle limit inside a frame (used only with LOADER_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader can accept byte; transfer when in_valid & in_ready
bram_we  output  1  BRAM write enable, one cycle per payload byte
bram_addr  output  ADDR_W  BRAM byte address
bram_din  output  8  BRAM write data
cpu_hold  output  1  1 = core held (PC and pipeline ticks frozen)
load_done  output  1  one-cycle pulse on verified frame
load_err  output  1  sticky error flag, cleared by next SYNC_BYTE or reset
byte_cnt  output  ADDR_W+1  payload bytes written in current frame

Behaviour:
- Reset (rst=0 on a clock edge), all outputs:
  - in_ready=1, bram_we=0, bram_addr=0, bram_din=0
  - cpu_hold=1, load_done=0, load_err=0, byte_cnt=0
  - state=IDLE
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit payload byte count, little-endian), LEN payload bytes, CKSUM.
  - CKSUM = 8-bit sum mod 256 of the payload bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CKSUM, DONE, ERROR.
- IDLE:
  - Accepted byte == SYNC_BYTE: clear load_err, byte_cnt, addr and the running sum; set cpu_hold=1; go to LEN_LO.
  - Any other byte: discard, stay in IDLE.
- LEN_LO: latch low length byte; go to LEN_HI.
- LEN_HI: latch high length byte, then evaluate len:
  - len > 2^ADDR_W: go to ERROR.
  - len == 0: go to CKSUM.
  - Otherwise: go to DATA.
- DATA:
  - Each accepted byte is registered: bram_we=1, bram_addr=byte_cnt[ADDR_W-1:0], bram_din=byte on the next cycle (write latency 1).
  - Same edge: byte_cnt increments and sum += byte.
  - When byte_cnt reaches len, go to CKSUM.
  - No wrap: the length check guarantees addr ≤ 2^ADDR_W-1.
- CKSUM: accepted byte compared with the sum.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE:
  - Lasts exactly one cycle: load_done=1, cpu_hold=0 from this cycle onward.
  - Then go to IDLE with cpu_hold held at 0.
- ERROR:
  - load_err=1, cpu_hold stays 1, in_ready=1.
  - An accepted SYNC_BYTE restarts the frame (go to LEN_LO) and clears load_err.
  - Other bytes are discarded.
- in_ready is 0 only in DONE; it is 1 in every other state. One byte is accepted per cycle at most; back-to-back bytes are supported at full rate.
- A SYNC_BYTE value inside LEN/DATA/CKSUM is ordinary data; no resync mid-frame.
- bram_we never asserts outside DATA processing. BRAM contents from a failed frame are left as-is (the core stays held).
- A new frame while the core is running (cpu_hold=0) reasserts cpu_hold on the SYNC_BYTE acceptance edge.
- Reset mid-frame: abort immediately with reset values; any write already registered is not issued.

Optional Feature:
LOADER_TIMEOUT_EN:
- Defined:
  - A counter runs in LEN_LO, LEN_HI, DATA and CKSUM; it resets on every accepted byte.
  - When it reaches TIMEOUT_CYC-1 without a transfer, go to ERROR with load_err=1.
  - The counter is held at 0 in IDLE, DONE and ERROR.
- Undefined: no counter logic; a stalled frame waits indefinitely.

Test Plan:
- Reset then stream A5 04 00 13 00 00 00 13 -> bram writes addr0=13, addr1..3=00; load_done pulses 1 cycle; cpu_hold falls to 0; byte_cnt=4.
- Frame A5 02 00 11 22 34 (wrong checksum, expect 33) -> two writes occur; load_err=1; cpu_hold stays 1; no load_done.
- Frame A5 01 10 (len 0x1001 > 4096) -> ERROR right after LEN_HI; zero bram_we pulses. Then a valid frame A5 01 00 7F 7F -> load_err clears; load_done pulses.
- Garbage 00 FF 5A, then A5 00 00 00 -> garbage discarded; empty frame succeeds; load_done=1; no writes.
- in_valid held high for a 4096-byte frame -> 4096 consecutive bram_we cycles, addr 0..4095; byte_cnt=4096; correct checksum gives done.
- Two scenarios:
  - rst=0 asserted mid-DATA: all outputs return to reset values the next cycle.
  - With LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, stop after A5 03 00 AA: ERROR after 16 idle cycles.
